pet_stats_engine: RTL

PET_STATS_ENGINE -- requirements
Module: pet_stats_engine

---
 rtl/pet_stats_engine.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pet_stats_engine.sv
// pet_stats_engine: virtual-pet stat channels with periodic decay, a command port and an AWAKE/SLEEP/DEAD FSM.
// Optional feature macro STATS_RANDOM_DECAY_EN: an LFSR picks a per-channel awake decay of 1 or 2.
module pet_stats_engine #(
    parameter int          NUM_STATS  = 5,
    parameter int          STAT_W     = 5,
    parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
    parameter int          LOW_THRESH = 4,
    parameter int          DEAD_TICKS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [2:0]                  cmd_sel,
    input  logic [STAT_W-1:0]           cmd_amt,
    output logic [NUM_STATS*STAT_W-1:0] stats_flat,
    output logic                        tick,
    output logic                        is_sleeping,
    output logic                        alarm,
    output logic                        dead,
    output logic                        cmd_err
);

    localparam logic [1:0] ST_AWAKE = 2'd0;
    localparam logic [1:0] ST_SLEEP = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_SLEEP = 2'b11;

    localparam int                HZ_W       = $clog2(DEAD_TICKS + 1);
    localparam int                ENERGY_LSB = (NUM_STATS - 1) * STAT_W;
    localparam logic [STAT_W-1:0] STAT_MAX   = '1;
    localparam logic [STAT_W-1:0] STAT_INIT  = {1'b1, {(STAT_W-1){1'b0}}};
    localparam logic [HZ_W-1:0]   HZ_LIMIT   = HZ_W'(DEAD_TICKS);

    logic [23:0]                  r_cnt;
    logic [1:0]                   r_state;
    logic [1:0]                   w_state_next;
    logic [NUM_STATS*STAT_W-1:0]  r_stats;
    logic [NUM_STATS*STAT_W-1:0]  w_stats_next;
    logic [HZ_W-1:0]              r_hz;
    logic [HZ_W-1:0]              w_hz_next;
    logic                         r_alarm;
    logic                         r_cmd_err;
    logic                         w_tick;
    logic                         w_accept;
    logic                         w_toggle;
    logic                         w_sel_bad;
    logic                         w_write;
    logic [NUM_STATS-1:0]         w_low;
    logic [STAT_W-1:0]            w_energy_next;
    logic [STAT_W-1:0]            w_hunger_next;

    // Saturating helpers widen by one bit so the carry/borrow is visible.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[STAT_W] ? STAT_MAX : sum[STAT_W-1:0];
    endfunction

    function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[STAT_W] ? '0 : diff[STAT_W-1:0];
    endfunction

    assign w_tick    = (r_cnt == MAX_COUNT - 24'd1);
    assign cmd_ready = (r_state != ST_DEAD);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_toggle  = w_accept && (cmd_op == OP_SLEEP);
    assign w_sel_bad = ({1'b0, cmd_sel} >= 4'(NUM_STATS));
    assign w_write   = w_accept && (cmd_op != OP_SLEEP) && !w_sel_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

`ifdef STATS_RANDOM_DECAY_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
`endif

    // Per channel: tick update first, then any command on the ticked value.
    for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_chan
        logic [STAT_W-1:0] w_cur;
        logic [STAT_W-1:0] w_dec;
        logic [STAT_W-1:0] w_ticked;
        logic [STAT_W-1:0] w_next;

        assign w_cur = r_stats[gi*STAT_W +: STAT_W];
`ifdef STATS_RANDOM_DECAY_EN
        assign w_dec = r_lfsr[gi] ? STAT_W'(2) : STAT_W'(1);
`else
        assign w_dec = STAT_W'(1);
`endif

        always_comb begin
            w_ticked = w_cur;
            if (w_tick && (r_state == ST_AWAKE)) begin
                w_ticked = sat_sub(w_cur, w_dec);
            end else if (w_tick && (r_state == ST_SLEEP) && (gi == NUM_STATS - 1)) begin
                w_ticked = sat_add(w_cur, STAT_W'(2));
            end
        end

        always_comb begin
            w_next = w_ticked;
            if (w_write && (cmd_sel == 3'(gi))) begin
                case (cmd_op)
                    OP_ADD:  w_next = sat_add(w_ticked, cmd_amt);
                    OP_SUB:  w_next = sat_sub(w_ticked, cmd_amt);
                    OP_SET:  w_next = cmd_amt;
                    default: w_next = w_ticked;
                endcase
            end
        end

        assign w_stats_next[gi*STAT_W +: STAT_W] = w_next;
        assign w_low[gi] = (w_cur < STAT_W'(LOW_THRESH));
    end

    assign w_energy_next = w_stats_next[ENERGY_LSB +: STAT_W];
    assign w_hunger_next = w_stats_next[STAT_W-1:0];

    always_comb begin
        w_hz_next = r_hz;
        if (r_state != ST_DEAD) begin
            if (w_hunger_next != '0) begin
                w_hz_next = '0;
            end else if (w_tick && (r_hz != HZ_LIMIT)) begin
                w_hz_next = r_hz + HZ_W'(1);
            end
        end
    end

    // Starvation overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_AWAKE: begin
                if (w_hz_next == HZ_LIMIT) begin
                    w_state_next = ST_DEAD;
                end else if (w_toggle || (w_tick && (w_energy_next == '0))) begin
                    w_state_next = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (w_hz_next == HZ_LIMIT) begin
                    w_state_next = ST_DEAD;
                end else if (w_toggle || (w_tick && (w_energy_next == STAT_MAX))) begin
                    w_state_next = ST_AWAKE;
                end
            end
            ST_DEAD:  w_state_next = ST_DEAD;
            default:  w_state_next = ST_AWAKE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_AWAKE;
            r_stats   <= {NUM_STATS{STAT_INIT}};
            r_hz      <= '0;
            r_alarm   <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_stats   <= w_stats_next;
            r_hz      <= w_hz_next;
            r_alarm   <= |w_low;
            r_cmd_err <= w_accept && (cmd_op != OP_SLEEP) && w_sel_bad;
        end
    end

    assign stats_flat  = r_stats;
    assign tick        = w_tick;
    assign is_sleeping = (r_state == ST_SLEEP);
    assign dead        = (r_state == ST_DEAD);
    assign alarm       = r_alarm;
    assign cmd_err     = r_cmd_err;

endmodule
